// File: rtl/display_pkg.sv
// Shared definitions for the display code encoder and the seven-segment decoder.
package display_pkg;

  localparam int unsigned CODE_W    = 3;
  localparam int unsigned NUM_CODES = 8;

  localparam logic [CODE_W-1:0] CODE_0 = 3'd0;
  localparam logic [CODE_W-1:0] CODE_1 = 3'd1;
  localparam logic [CODE_W-1:0] CODE_2 = 3'd2;
  localparam logic [CODE_W-1:0] CODE_3 = 3'd3;
  localparam logic [CODE_W-1:0] CODE_4 = 3'd4;
  localparam logic [CODE_W-1:0] CODE_5 = 3'd5;
  localparam logic [CODE_W-1:0] CODE_6 = 3'd6;
  localparam logic [CODE_W-1:0] CODE_7 = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

endpackage

// File: rtl/display_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning cur+1 .. cur+7, then cur itself.
module display_rr_arbiter
  import display_pkg::*;
(
  input  logic [NUM_CODES-1:0] req,
  input  logic [CODE_W-1:0]    cur,
  output logic [CODE_W-1:0]    pick,
  output logic                 found
);

  logic [CODE_W-1:0] idx;

  // Scan farthest offset first so the nearest set request is the last to win.
  always_comb begin
    pick  = CODE_0;
    found = 1'b0;
    idx   = CODE_0;
    for (int k = int'(NUM_CODES); k >= 1; k--) begin
      idx = cur + CODE_W'(k);
      if (req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_code_encoder.sv
// Rotates the displayed 3-bit code between active requests, holding each for DWELL_CYCLES.
module display_code_encoder
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CODES-1:0] req,
  output logic                 selector,
  output logic                 entry_Bit1,
  output logic                 entry_Bit0,
  output logic                 active,
  output logic                 code_change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_e            state_q;
  logic [CODE_W-1:0] code_q;
  logic              active_q;
  logic              change_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CODE_W-1:0] arb_cur;
  logic [CODE_W-1:0] pick;
  logic              found;

  // From IDLE, starting the scan after code 7 yields the lowest set index.
  assign arb_cur = (state_q == IDLE) ? CODE_7 : code_q;

  display_rr_arbiter u_arb (
    .req   (req),
    .cur   (arb_cur),
    .pick  (pick),
    .found (found)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      code_q   <= CODE_0;
      active_q <= 1'b0;
      change_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      change_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q  <= SHOW;
            code_q   <= pick;
            active_q <= 1'b1;
            change_q <= (pick != CODE_0);
            cnt_q    <= '0;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (found) begin
              code_q   <= pick;
              change_q <= (pick != code_q);
            end else begin
              state_q  <= IDLE;
              code_q   <= CODE_0;
              active_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          code_q   <= CODE_0;
          active_q <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign {selector, entry_Bit1, entry_Bit0} = code_q;
  assign active      = active_q;
  assign code_change = change_q;

endmodule
